// File: rtl/miriscv_mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: one FSM and datapath shared by MUL* and DIV/REM.
// Define MIRISCV_MDU_RESULT_CACHE_EN to reuse the last completed iterative result.
module miriscv_mdu_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 8,
    parameter int DIV_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mdu_req_i,
    input  logic [XLEN-1:0] mdu_port_a_i,
    input  logic [XLEN-1:0] mdu_port_b_i,
    input  logic [2:0]      mdu_op_i,
    input  logic            mdu_kill_i,
    input  logic            mdu_keep_i,
    output logic [XLEN-1:0] mdu_result_o,
    output logic            mdu_stall_req_o
);

    localparam int MUL_N = XLEN / MUL_STEP;
    localparam int DIV_N = XLEN / DIV_STEP;
    localparam int CW    = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              rem_neg_q;
    logic [XLEN-1:0]   opd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    logic              is_div, a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_result;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_result;
    logic              start, busy, last;

    always_comb begin
        is_div   = mdu_op_i[2];
        a_signed = (mdu_op_i == OP_MULH) || (mdu_op_i == OP_MULHSU) ||
                   (mdu_op_i == OP_DIV)  || (mdu_op_i == OP_REM);
        b_signed = (mdu_op_i == OP_MULH) || (mdu_op_i == OP_DIV) || (mdu_op_i == OP_REM);
        sa       = a_signed & mdu_port_a_i[XLEN-1];
        sb       = b_signed & mdu_port_b_i[XLEN-1];
        mag_a    = sa ? -mdu_port_a_i : mdu_port_a_i;
        mag_b    = sb ? -mdu_port_b_i : mdu_port_b_i;
    end

    // Trivial operands resolve without iterating; op[1] selects remainder for divides.
    always_comb begin
        fast_hit    = 1'b0;
        fast_result = '0;
        if (!is_div) begin
            fast_hit = (mdu_port_a_i == '0) || (mdu_port_b_i == '0);
        end else if (mdu_port_b_i == '0) begin
            fast_hit    = 1'b1;
            fast_result = mdu_op_i[1] ? mdu_port_a_i : '1;
        end else if (!mdu_op_i[0] && (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (&mdu_port_b_i)) begin
            fast_hit    = 1'b1;
            fast_result = mdu_op_i[1] ? '0 : mdu_port_a_i;
        end
    end

    // Multiply: the accumulator shifts right, consuming MUL_STEP multiplier bits from its low end.
    logic [XLEN+MUL_STEP-1:0] mul_sum;
    logic [2*XLEN-1:0]        mul_acc_next, prod_final;
    logic [XLEN-1:0]          mul_result;

    always_comb begin
        mul_sum      = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
                       ({{MUL_STEP{1'b0}}, opd_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]});
        mul_acc_next = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
        prod_final   = neg_q ? -mul_acc_next : mul_acc_next;
        mul_result   = (op_q == OP_MUL) ? prod_final[XLEN-1:0] : prod_final[2*XLEN-1:XLEN];
    end

    // Divide: accumulator holds {partial remainder, dividend/quotient}, shifting left per bit.
    logic [2*XLEN-1:0] div_acc;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff, quo_final, rem_final, div_result;

    always_comb begin
        div_acc   = acc_q;
        div_shift = '0;
        div_diff  = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            div_shift = div_acc[2*XLEN-1:XLEN-1];
            div_diff  = div_shift[XLEN-1:0] - opd_q;
            if (div_shift >= {1'b0, opd_q})
                div_acc = {div_diff, div_acc[XLEN-2:0], 1'b1};
            else
                div_acc = {div_acc[2*XLEN-2:0], 1'b0};
        end
        quo_final  = neg_q ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
        rem_final  = rem_neg_q ? -div_acc[2*XLEN-1:XLEN] : div_acc[2*XLEN-1:XLEN];
        div_result = op_q[1] ? rem_final : quo_final;
    end

    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
    assign last = (cnt_q == CW'(1));

`ifdef MIRISCV_MDU_RESULT_CACHE_EN
    logic            cache_valid_q;
    logic [2:0]      cache_op_q;
    logic [XLEN-1:0] cache_a_q, cache_b_q, cache_q_q, cache_r_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            op_match;

    // DIV/REM pairs of equal signedness share one entry since both results are stored.
    always_comb begin
        op_match     = (mdu_op_i == cache_op_q) ||
                       (mdu_op_i[2] && cache_op_q[2] && (mdu_op_i[0] == cache_op_q[0]));
        cache_hit    = cache_valid_q && op_match &&
                       (mdu_port_a_i == cache_a_q) && (mdu_port_b_i == cache_b_q);
        cache_result = (mdu_op_i[2] && mdu_op_i[1]) ? cache_r_q : cache_q_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_valid_q <= 1'b0;
            cache_op_q    <= '0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_q_q     <= '0;
            cache_r_q     <= '0;
            a_q           <= '0;
            b_q           <= '0;
        end else begin
            if (start) begin
                a_q <= mdu_port_a_i;
                b_q <= mdu_port_b_i;
            end
            if (mdu_kill_i) begin
                cache_valid_q <= 1'b0;
            end else if (busy && last) begin
                cache_valid_q <= 1'b1;
                cache_op_q    <= op_q;
                cache_a_q     <= a_q;
                cache_b_q     <= b_q;
                cache_q_q     <= (state_q == S_MUL) ? mul_result : quo_final;
                cache_r_q     <= rem_final;
            end
        end
    end
`else
    always_comb begin
        cache_hit    = 1'b0;
        cache_result = '0;
    end
`endif

    always_comb begin
        state_d         = state_q;
        mdu_stall_req_o = 1'b0;
        mdu_result_o    = '0;
        start           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mdu_req_i && !mdu_kill_i) begin
                    if (fast_hit) begin
                        mdu_result_o = fast_result;
                    end else if (cache_hit) begin
                        mdu_result_o = cache_result;
                    end else begin
                        mdu_stall_req_o = 1'b1;
                        start           = 1'b1;
                        state_d         = is_div ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                mdu_stall_req_o = !mdu_kill_i;
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                if (!mdu_kill_i) mdu_result_o = result_q;
                if (!mdu_keep_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Kill wins over keep and over a fresh request.
        if (mdu_kill_i) state_d = S_IDLE;
        if (rst_i) begin
            mdu_stall_req_o = 1'b0;
            mdu_result_o    = '0;
            start           = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opd_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q      <= mdu_op_i;
                neg_q     <= sa ^ sb;
                rem_neg_q <= sa;
                opd_q     <= is_div ? mag_b : mag_a;
                acc_q     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                cnt_q     <= is_div ? CW'(DIV_N) : CW'(MUL_N);
            end else if (busy && !mdu_kill_i) begin
                acc_q <= (state_q == S_MUL) ? mul_acc_next : div_acc;
                cnt_q <= cnt_q - CW'(1);
                if (last) result_q <= (state_q == S_MUL) ? mul_result : div_result;
            end
        end
    end

endmodule

// File: tb/tb_miriscv_mdu_iter.sv
// Testbench for miriscv_mdu_iter (XLEN=32, MUL_STEP=8, DIV_STEP=1): directed table, control
// sequences and random operations checked against an arithmetic reference model.
module tb_miriscv_mdu_iter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 100;
`ifdef MIRISCV_MDU_RESULT_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req, kill, keep;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        stall;

    int total = 0;
    int bad   = 0;

    bit          cValid;
    logic [2:0]  cOp;
    logic [31:0] cA, cB;

    always #5 clk = ~clk;

    miriscv_mdu_iter #(.XLEN(XLEN), .MUL_STEP(8), .DIV_STEP(1)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mdu_req_i      (req),
        .mdu_port_a_i   (a),
        .mdu_port_b_i   (b),
        .mdu_op_i       (op),
        .mdu_kill_i     (kill),
        .mdu_keep_i     (keep),
        .mdu_result_o   (result),
        .mdu_stall_req_o(stall)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          stalls;
    } vec_t;

    vec_t vecs[13];

    // Plain 64-bit arithmetic reference for all eight RV32M operations.
    function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] t;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        t  = '0;
        case (o)
            3'd0: t = ux * uy;
            3'd1: t = sx * sy;
            3'd2: t = sx * uy;
            3'd3: t = ux * uy;
            default: ;
        endcase
        case (o)
            3'd0: return t[31:0];
            3'd1, 3'd2, 3'd3: return t[63:32];
            3'd4: begin if (y == 0) return 32'hFFFFFFFF; t = sx / sy; return t[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; t = ux / uy; return t[31:0]; end
            3'd6: begin if (y == 0) return x; t = sx % sy; return t[31:0]; end
            default: begin if (y == 0) return x; t = ux % uy; return t[31:0]; end
        endcase
    endfunction

    function automatic bit isFast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[2]) return (x == 0) || (y == 0);
        return (y == 0) || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF);
    endfunction

    function automatic bit cacheHit(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return CACHE_ON && cValid && x == cA && y == cB &&
               (o == cOp || (o[2] && cOp[2] && o[0] == cOp[0]));
    endfunction

    function automatic int expStalls(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (isFast(o, x, y) || cacheHit(o, x, y)) return 0;
        return o[2] ? 33 : 5;
    endfunction

    task automatic modelCommit(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!isFast(o, x, y) && !cacheHit(o, x, y)) begin
            cValid = 1'b1;
            cOp    = o;
            cA     = x;
            cB     = y;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Entered and left at a falling edge; holds the request until stall drops.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] res, output int stalls);
        op = o; a = x; b = y; req = 1'b1;
        stalls = 0;
        #1;
        while (stall === 1'b1 && stalls < LIMIT) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= LIMIT) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout: got %0d stall cycles expected below %0d", stalls, LIMIT);
        end
        res = result;
        req = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res, x, y, expR;
        logic [2:0]  o;
        int          st, es;

        vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 5};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 5};
        vecs[2]  = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 5};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5};
        vecs[4]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[5]  = '{3'd1, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 5};
        vecs[6]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        vecs[7]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[8]  = '{3'd5, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0};
        vecs[9]  = '{3'd7, 32'h00000005, 32'h00000000, 32'h00000005, 0};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};
        vecs[12] = '{3'd5, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 33};

        rst = 1'b1; req = 1'b0; kill = 1'b0; keep = 1'b0;
        op = 3'd0; a = '0; b = '0; cValid = 1'b0;

        @(negedge clk);
        req = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
        #1;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            es = cacheHit(vecs[i].op, vecs[i].a, vecs[i].b) ? 0 : vecs[i].stalls;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, st);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].res);
            checkOutput($sformatf("vec%0d_stalls", i), 32'(st), 32'(es));
            modelCommit(vecs[i].op, vecs[i].a, vecs[i].b);
        end

        // Kill in the fourth stall cycle, then an immediate multiply.
        op = 3'd5; a = 32'd100; b = 32'd7; req = 1'b1;
        #1;
        checkOutput("kill_start_stall", 32'(stall), 32'd1);
        repeat (3) @(negedge clk);
        kill = 1'b1;
        #1;
        checkOutput("kill_cycle_stall", 32'(stall), 32'd0);
        cValid = 1'b0;
        @(negedge clk);
        kill = 1'b0;
        applyStimulus(3'd0, 32'd6, 32'd7, res, st);
        checkOutput("after_kill_result", res, 32'd42);
        checkOutput("after_kill_stalls", 32'(st), 32'd5);
        modelCommit(3'd0, 32'd6, 32'd7);

        // Reset pulse in the middle of a divide.
        op = 3'd5; a = 32'h0000FFFF; b = 32'd3; req = 1'b1;
        #1;
        checkOutput("rst_div_start_stall", 32'(stall), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_stall", 32'(stall), 32'd0);
        checkOutput("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        #1;
        checkOutput("rst_after_stall", 32'(stall), 32'd0);
        checkOutput("rst_after_result", result, 32'd0);
        cValid = 1'b0;
        @(negedge clk);

        // Keep holds the finished result in DONE.
        es = expStalls(3'd5, 32'd100, 32'd7);
        op = 3'd5; a = 32'd100; b = 32'd7; req = 1'b1;
        st = 0;
        #1;
        while (stall === 1'b1 && st < LIMIT) begin
            st++;
            @(negedge clk);
            #1;
        end
        checkOutput("keep_stalls", 32'(st), 32'(es));
        checkOutput("keep_result", result, 32'd14);
        modelCommit(3'd5, 32'd100, 32'd7);
        keep = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("keep_hold%0d_stall", i), 32'(stall), 32'd0);
            checkOutput($sformatf("keep_hold%0d_result", i), result, 32'd14);
        end
        keep = 1'b0; req = 1'b0;
        @(negedge clk);

        es = expStalls(3'd5, 32'd100, 32'd7);
        applyStimulus(3'd5, 32'd100, 32'd7, res, st);
        checkOutput("repeat_result", res, 32'd14);
        checkOutput("repeat_stalls", 32'(st), 32'(CACHE_ON ? 0 : 33));
        checkOutput("repeat_model_stalls", 32'(st), 32'(es));
        modelCommit(3'd5, 32'd100, 32'd7);

        x = 32'd1; y = 32'd1;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) != 0) begin
                x = pick();
                y = pick();
            end
            expR = refResult(o, x, y);
            es   = expStalls(o, x, y);
            applyStimulus(o, x, y, res, st);
            checkOutput($sformatf("rand%0d_op%0d_result", i, o), res, expR);
            checkOutput($sformatf("rand%0d_op%0d_stalls", i, o), 32'(st), 32'(es));
            modelCommit(o, x, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
